// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset core.
// Latency: none (constants and one combinational helper).
// Backpressure: n/a.
// Contents: opcode/funct3/funct7 codes, FSM state codes, ALU-op codes,
// immediate-format codes and an instruction legality check.
package mc_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef logic [2:0] state_t;
    localparam state_t ST_FETCH  = 3'd0;
    localparam state_t ST_DECODE = 3'd1;
    localparam state_t ST_EXEC   = 3'd2;
    localparam state_t ST_MEM    = 3'd3;
    localparam state_t ST_WB     = 3'd4;
    localparam state_t ST_HALT   = 3'd5;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // Only the implemented subset is legal; shifts, sltu and byte/half
    // accesses fall out as illegal so they halt instead of misexecuting.
    function automatic logic op_legal(input logic [31:0] ir);
        logic [2:0] f3;
        logic       alu_f3;
        f3     = ir[14:12];
        alu_f3 = f3 inside {F3_ADD, F3_SLT, F3_XOR, F3_OR, F3_AND};
        case (ir[6:0])
            OP_R:              return alu_f3 && (ir[31:25] == F7_BASE ||
                                                 (ir[31:25] == F7_SUB && f3 == F3_ADD));
            OP_I:              return alu_f3;
            OP_LOAD, OP_STORE: return f3 == F3_LW;
            OP_BRANCH:         return f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE};
            OP_JALR:           return f3 == 3'b000;
            OP_JAL, OP_LUI:    return 1'b1;
            default:           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// Architectural register file: NREGS x XLEN, x0 reads as zero.
// Latency: reads combinational, write lands at the next clk edge.
// Backpressure: none; a write is taken whenever we=1.
// Ports: clk, rst (sync, active-high, clears all registers),
//        rs1_idx/rs1_dat, rs2_idx/rs2_dat (read), we/rd_idx/rd_dat (write).
module mc_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREGS)-1:0] rs1_idx,
    input  logic [$clog2(NREGS)-1:0] rs2_idx,
    output logic [XLEN-1:0]          rs1_dat,
    output logic [XLEN-1:0]          rs2_dat,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] rd_idx,
    input  logic [XLEN-1:0]          rd_dat
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && rd_idx != '0) begin
            regs[rd_idx] <= rd_dat;
        end
    end

    assign rs1_dat = (rs1_idx == '0) ? '0 : regs[rs1_idx];
    assign rs2_dat = (rs2_idx == '0) ? '0 : regs[rs2_idx];

endmodule

// File: rtl/multicycle_rv_core.sv
// Multi-cycle RV32I-subset core: one ALU and one unified memory port reused across states.
// Latency (mem_ready=1): branch 3, ALU/lui/jal/jalr/sw 4, lw 5 cycles; +1 per memory wait cycle.
// Backpressure: FETCH and MEM hold mem_req/addr/we/wdata stable until mem_ready.
// Ports: clk, rst (sync, active-high); mem_req/mem_we/mem_addr/mem_wdata out,
//        mem_rdata/mem_ready in; retire (1-cycle pulse per instruction), halted (sticky).
// Option MC_PERF_CNT_EN adds cycle_cnt[63:0] and instret_cnt[63:0] outputs.
module multicycle_rv_core #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            retire,
    output logic            halted
`ifdef MC_PERF_CNT_EN
    ,
    output logic [63:0]     cycle_cnt,
    output logic [63:0]     instret_cnt
`endif
);
    import mc_pkg::*;

    localparam int AW = $clog2(NREGS);

    state_t          state;
    logic [31:0]     ir;
    logic [XLEN-1:0] pc, oldpc, a, b, alu_out, mdr;
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [2:0]      imm_fmt, alu_sel;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm, alu_in1, alu_in2, alu_y, wb_dat, rs1_dat, rs2_dat;
    logic            br_taken, bad_idx, uses_rs1, uses_rs2, uses_rd;

    assign opcode = ir[6:0];
    assign f3     = ir[14:12];

    // Immediate generator.
    always_comb begin
        case (opcode)
            OP_STORE:  imm_fmt = IMM_S;
            OP_BRANCH: imm_fmt = IMM_B;
            OP_LUI:    imm_fmt = IMM_U;
            OP_JAL:    imm_fmt = IMM_J;
            default:   imm_fmt = IMM_I;
        endcase
        case (imm_fmt)
            IMM_S:   imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_U:   imm32 = {ir[31:12], 12'b0};
            IMM_J:   imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm32 = {{20{ir[31]}}, ir[31:20]};
        endcase
        imm = XLEN'($signed(imm32));
    end

    // Shared ALU: DECODE computes oldpc+imm (branch/jal target); EXEC does the real op.
    assign alu_in1 = (state == ST_DECODE) ? oldpc : a;
    assign alu_in2 = (state == ST_EXEC && opcode == OP_R) ? b : imm;

    always_comb begin
        alu_sel = ALU_ADD;
        if (state == ST_EXEC && (opcode == OP_R || opcode == OP_I)) begin
            case (f3)
                F3_SLT:  alu_sel = ALU_SLT;
                F3_XOR:  alu_sel = ALU_XOR;
                F3_OR:   alu_sel = ALU_OR;
                F3_AND:  alu_sel = ALU_AND;
                default: alu_sel = (opcode == OP_R && ir[30]) ? ALU_SUB : ALU_ADD;
            endcase
        end
        case (alu_sel)
            ALU_SUB: alu_y = alu_in1 - alu_in2;
            ALU_AND: alu_y = alu_in1 & alu_in2;
            ALU_OR:  alu_y = alu_in1 | alu_in2;
            ALU_XOR: alu_y = alu_in1 ^ alu_in2;
            ALU_SLT: alu_y = {{(XLEN-1){1'b0}}, $signed(alu_in1) < $signed(alu_in2)};
            default: alu_y = alu_in1 + alu_in2;
        endcase
    end

    // Branch comparator is separate so the ALU stays free for a+imm in EXEC.
    always_comb begin
        case (f3)
            F3_BEQ:  br_taken = (a == b);
            F3_BNE:  br_taken = (a != b);
            F3_BLT:  br_taken = ($signed(a) < $signed(b));
            default: br_taken = !($signed(a) < $signed(b));
        endcase
    end

    // With fewer than 32 registers, a used index field with bit 4 set is a fault.
    assign uses_rs1 = !(opcode == OP_LUI || opcode == OP_JAL);
    assign uses_rs2 = opcode inside {OP_R, OP_STORE, OP_BRANCH};
    assign uses_rd  = !(opcode inside {OP_STORE, OP_BRANCH});
    assign bad_idx  = (NREGS < 32) &&
                      ((uses_rs1 && ir[19]) || (uses_rs2 && ir[24]) || (uses_rd && ir[11]));

    always_comb begin
        case (opcode)
            OP_LOAD:         wb_dat = mdr;
            OP_JAL, OP_JALR: wb_dat = oldpc + XLEN'(4);
            default:         wb_dat = alu_out;
        endcase
    end

    mc_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .rs1_idx (ir[15 +: AW]),
        .rs2_idx (ir[20 +: AW]),
        .rs1_dat (rs1_dat),
        .rs2_dat (rs2_dat),
        .we      (state == ST_WB && !rst),
        .rd_idx  (ir[7 +: AW]),
        .rd_dat  (wb_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_FETCH;
            pc      <= RESET_PC;
            oldpc   <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            case (state)
                ST_FETCH: if (mem_ready) begin
                    ir    <= mem_rdata[31:0];
                    oldpc <= pc;
                    pc    <= pc + XLEN'(4);
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    a       <= rs1_dat;
                    b       <= rs2_dat;
                    alu_out <= alu_y;
                    state   <= (op_legal(ir) && !bad_idx) ? ST_EXEC : ST_HALT;
                end
                ST_EXEC: begin
                    alu_out <= alu_y;
                    state   <= ST_WB;
                    case (opcode)
                        OP_LOAD, OP_STORE:
                            state <= (alu_y[1:0] != 2'b00) ? ST_HALT : ST_MEM;
                        OP_BRANCH: begin
                            if (br_taken) pc <= alu_out;
                            state <= ST_FETCH;
                        end
                        OP_JAL:  pc <= alu_out;
                        OP_JALR: pc <= {alu_y[XLEN-1:1], 1'b0};
                        OP_LUI:  alu_out <= imm;
                        default: ;
                    endcase
                end
                ST_MEM: if (mem_ready) begin
                    mdr   <= mem_rdata;
                    state <= (opcode == OP_STORE) ? ST_FETCH : ST_WB;
                end
                ST_WB:   state <= ST_FETCH;
                default: state <= ST_HALT;
            endcase
        end
    end

    assign mem_req   = !rst && (state == ST_FETCH || state == ST_MEM);
    assign mem_we    = !rst && state == ST_MEM && opcode == OP_STORE;
    assign mem_addr  = (state == ST_MEM) ? alu_out : pc;
    assign mem_wdata = b;
    assign halted    = (state == ST_HALT);
    assign retire    = !rst && ((state == ST_WB) ||
                                (state == ST_MEM && opcode == OP_STORE && mem_ready) ||
                                (state == ST_EXEC && opcode == OP_BRANCH));

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (!halted) cycle_cnt   <= cycle_cnt + 64'd1;
            if (retire)  instret_cnt <= instret_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_rv_core.sv
// Bench for multicycle_rv_core: word memory with programmable wait states,
// a table of instructions with hand-computed results, then hand-written
// sequences for wait states, halts and reset mid-transfer.
module tb_multicycle_rv_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MC_PERF_CNT_EN
    logic [63:0] cycle_cnt, instret_cnt;
`endif

    multicycle_rv_core #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .retire    (retire),
        .halted    (halted)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: 256 words, loaded through a poke port so only one process writes it.
    logic [31:0] mem [0:255];
    logic        load_en = 1'b0;
    logic [7:0]  load_idx = '0;
    logic [31:0] load_dat = '0;
    int          wait_n = 0;
    int          wcnt = 0;

    assign mem_ready = mem_req && (wcnt >= wait_n);
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (load_en) mem[load_idx] <= load_dat;
        else if (mem_req && mem_ready && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;
    end

    // Address/direction must not move while a transfer is waiting.
    logic        holding = 1'b0;
    logic [31:0] hold_addr = '0;
    logic        hold_we = 1'b0;
    int          addr_bad = 0;
    int          hold_seen = 0;
    always @(posedge clk) begin
        if (holding && mem_req) begin
            hold_seen <= hold_seen + 1;
            if (mem_addr != hold_addr || mem_we != hold_we) addr_bad <= addr_bad + 1;
        end
        holding   <= mem_req && !mem_ready;
        hold_addr <= mem_addr;
        hold_we   <= mem_we;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Tiny assembler.
    function automatic logic [31:0] r_t(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] i_t(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
        return {12'(imm), 5'(rs1), f3, 5'(rd), op};
    endfunction
    function automatic logic [31:0] s_t(input int imm, input int rs2, input int rs1);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] b_t(input int imm, input int rs2, input int rs1,
                                        input logic [2:0] f3);
        logic [12:0] im;
        im = 13'(imm);
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), f3, im[4:1], im[11], 7'h63};
    endfunction
    function automatic logic [31:0] j_t(input int imm, input int rd);
        logic [20:0] im;
        im = 21'(imm);
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6F};
    endfunction

    typedef struct {
        logic [31:0] at;
        logic [31:0] ins;
        int          cyc;
        int          rd;
        logic [31:0] val;
        logic [31:0] npc;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    task automatic poke(input logic [31:0] addr, input logic [31:0] dat);
        load_idx = addr[9:2];
        load_dat = dat;
        load_en  = 1'b1;
        @(posedge clk);
        #1 load_en = 1'b0;
    endtask

    // Run one instruction: count cycles up to and including the retire cycle,
    // then step past the following edge so its register/pc update is visible.
    task automatic step(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            cyc++;
            if (retire) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_quiet(input int n, output int rets);
        rets = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (retire) rets++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit ok;
        int rets;

        //           at     instruction                                cyc rd  value         next pc
        tbl[0]  = '{32'h00, i_t(5, 0, 3'd0, 1, 7'h13),                  4, 1,  32'h5,        32'h04};
        tbl[1]  = '{32'h04, i_t(-3, 0, 3'd0, 2, 7'h13),                 4, 2,  32'hFFFFFFFD, 32'h08};
        tbl[2]  = '{32'h08, r_t(7'h00, 2, 1, 3'd0, 3),                  4, 3,  32'h2,        32'h0C};
        tbl[3]  = '{32'h0C, r_t(7'h20, 2, 1, 3'd0, 5),                  4, 5,  32'h8,        32'h10};
        tbl[4]  = '{32'h10, r_t(7'h00, 1, 2, 3'd2, 6),                  4, 6,  32'h1,        32'h14};
        tbl[5]  = '{32'h14, i_t(-1, 1, 3'd2, 7, 7'h13),                 4, 7,  32'h0,        32'h18};
        tbl[6]  = '{32'h18, {20'h12345, 5'd8, 7'h37},                   4, 8,  32'h12345000, 32'h1C};
        tbl[7]  = '{32'h1C, r_t(7'h00, 1, 8, 3'd6, 9),                  4, 9,  32'h12345005, 32'h20};
        tbl[8]  = '{32'h20, j_t(16, 1),                                 4, 1,  32'h24,       32'h30};
        tbl[9]  = '{32'h30, i_t(0, 1, 3'd0, 0, 7'h67),                  4, 0,  32'h0,        32'h24};
        tbl[10] = '{32'h24, r_t(7'h00, 8, 9, 3'd4, 10),                 4, 10, 32'h5,        32'h28};
        tbl[11] = '{32'h28, i_t(-1, 0, 3'd0, 11, 7'h13),                4, 11, 32'hFFFFFFFF, 32'h2C};
        tbl[12] = '{32'h2C, j_t(8, 0),                                  4, 0,  32'h0,        32'h34};
        tbl[13] = '{32'h34, b_t(8, 6, 11, 3'd4),                        3, 11, 32'hFFFFFFFF, 32'h3C};
        tbl[14] = '{32'h3C, b_t(8, 6, 11, 3'd5),                        3, 6,  32'h1,        32'h40};
        tbl[15] = '{32'h40, b_t(8, 0, 0, 3'd0),                         3, 0,  32'h0,        32'h48};
        tbl[16] = '{32'h48, b_t(8, 10, 10, 3'd1),                       3, 10, 32'h5,        32'h4C};
        tbl[17] = '{32'h4C, i_t(32'hF0, 11, 3'd7, 13, 7'h13),           4, 13, 32'hF0,       32'h50};
        tbl[18] = '{32'h50, i_t(32'h100, 3, 3'd6, 14, 7'h13),          4, 14, 32'h102,      32'h54};
        tbl[19] = '{32'h54, i_t(5, 0, 3'd0, 1, 7'h13),                  4, 1,  32'h5,        32'h58};

        // Load the program while the core is held in reset.
        for (int i = 0; i < NV; i++) poke(tbl[i].at, tbl[i].ins);
        poke(32'h58, s_t(8, 1, 0));                   // sw  x1,8(x0)
        poke(32'h5C, i_t(8, 0, 3'd2, 4, 7'h03));      // lw  x4,8(x0)
        poke(32'h60, i_t(6, 0, 3'd2, 15, 7'h03));     // lw  x15,6(x0): misaligned

        @(negedge clk);
        check("rst mem_req", mem_req, 1'b0);
        check("rst retire", retire, 1'b0);
        check("rst halted", halted, 1'b0);
        check("rst pc", u_dut.pc, 32'h0);
        check("rst x1", u_dut.u_rf.regs[1], 32'h0);

        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            step(cyc, ok);
            check($sformatf("v%0d retired", i), ok, 1'b1);
            check($sformatf("v%0d cycles", i), cyc, tbl[i].cyc);
            check($sformatf("v%0d x%0d", i, tbl[i].rd), u_dut.u_rf.regs[tbl[i].rd], tbl[i].val);
            check($sformatf("v%0d pc", i), u_dut.pc, tbl[i].npc);
        end

        // Store then load with two wait cycles per transfer.
        wait_n = 2;
        step(cyc, ok);
        check("sw retired", ok, 1'b1);
        check("sw cycles", cyc, 8);
        check("sw mem[8]", mem[2], 32'h5);
        step(cyc, ok);
        check("lw retired", ok, 1'b1);
        check("lw cycles", cyc, 9);
        check("lw x4", u_dut.u_rf.regs[4], 32'h5);
        wait_n = 0;

        // Misaligned load halts without retiring or touching x15.
        run_quiet(8, rets);
        check("misalign halted", halted, 1'b1);
        check("misalign mem_req", mem_req, 1'b0);
        check("misalign retires", rets, 0);
        check("misalign x15", u_dut.u_rf.regs[15], 32'h0);

        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst2 pc", u_dut.pc, 32'h0);
        check("rst2 halted", halted, 1'b0);

        // Illegal opcode at the reset vector.
        poke(32'h00, 32'h0000007F);
        @(posedge clk);
        #1 rst = 1'b0;
        run_quiet(8, rets);
        check("illegal halted", halted, 1'b1);
        check("illegal mem_req", mem_req, 1'b0);
        check("illegal retires", rets, 0);

        // Reset while a fetch is waiting, then a clean restart.
        rst = 1'b1;
        poke(32'h00, tbl[0].ins);
        wait_n = 5;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("wait mem_req", mem_req, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst mem_req", mem_req, 1'b0);
        check("midrst pc", u_dut.pc, 32'h0);
        check("midrst x1", u_dut.u_rf.regs[1], 32'h0);
`ifdef MC_PERF_CNT_EN
        check("midrst cycle_cnt", cycle_cnt, 64'd0);
        check("midrst instret_cnt", instret_cnt, 64'd0);
`endif
        wait_n = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        step(cyc, ok);
        check("restart retired", ok, 1'b1);
        check("restart cycles", cyc, 4);
        check("restart x1", u_dut.u_rf.regs[1], 32'h5);
        check("restart pc", u_dut.pc, 32'h4);
`ifdef MC_PERF_CNT_EN
        check("restart cycle_cnt", cycle_cnt, 64'd4);
        check("restart instret_cnt", instret_cnt, 64'd1);
`endif

        check("addr stable", addr_bad, 0);
        check("wait cycles seen", hold_seen >= 8, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
